// File: rtl/clock_gearbox.sv
// clock_gearbox: synchronised, stretched reset release plus NCHAN programmable clock-enable strobes.
// Optional push-button single-step mode is built when CLOCK_GEARBOX_SINGLE_STEP_EN is defined.
module clock_gearbox #(
  parameter int NCHAN        = 2,
  parameter int DIV_W        = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 4096
`ifdef CLOCK_GEARBOX_SINGLE_STEP_EN
  ,
  parameter int DEB_W        = 16
`endif
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NCHAN*DIV_W-1:0] div,
  input  logic                   load,
`ifdef CLOCK_GEARBOX_SINGLE_STEP_EN
  input  logic                   step_mode,
  input  logic                   step,
`endif
  output logic                   resetn,
  output logic [NCHAN-1:0]       en
);

  localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(RESET_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic                   resetn_q, resetn_d;

  // Hold counter starts once the synchroniser reports release and saturates at RESET_CYCLES.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    hold_d = hold_q;
    if (sync_q[SYNC_STAGES-1] && (hold_q != HOLD_DONE))
      hold_d = hold_q + HOLD_W'(1);
    resetn_d = (hold_q == HOLD_DONE);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q   <= '0;
      hold_q   <= '0;
      resetn_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      hold_q   <= hold_d;
      resetn_q <= resetn_d;
    end
  end

  logic freeze;
  logic step_pulse;

`ifdef CLOCK_GEARBOX_SINGLE_STEP_EN
  logic [1:0]       step_sync_q, step_sync_d;
  logic             step_prev_q, step_prev_d;
  logic             lock_act_q, lock_act_d;
  logic [DEB_W-1:0] lock_cnt_q, lock_cnt_d;
  logic             step_pulse_q, step_pulse_d;
  logic             accept;

  // Accepted edges open a 2^DEB_W-cycle lockout window that swallows button bounce.
  always_comb begin
    step_sync_d = {step_sync_q[0], step};
    step_prev_d = step_sync_q[1];
    accept      = step_sync_q[1] && !step_prev_q && !lock_act_q;
    lock_act_d  = lock_act_q;
    lock_cnt_d  = lock_cnt_q;
    if (accept) begin
      lock_act_d = 1'b1;
      lock_cnt_d = '0;
    end else if (lock_act_q) begin
      lock_cnt_d = lock_cnt_q + DEB_W'(1);
      if (lock_cnt_q == '1)
        lock_act_d = 1'b0;
    end
    step_pulse_d = accept && step_mode && resetn_q;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      step_sync_q  <= '0;
      step_prev_q  <= 1'b0;
      lock_act_q   <= 1'b0;
      lock_cnt_q   <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      step_sync_q  <= step_sync_d;
      step_prev_q  <= step_prev_d;
      lock_act_q   <= lock_act_d;
      lock_cnt_q   <= lock_cnt_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign freeze     = step_mode && resetn_q;
  assign step_pulse = step_pulse_q;
`else
  assign freeze     = 1'b0;
  assign step_pulse = 1'b0;
`endif

  logic [NCHAN-1:0][DIV_W-1:0] div_v;
  logic [NCHAN-1:0][DIV_W-1:0] shadow_q, shadow_d;
  logic [NCHAN-1:0][DIV_W-1:0] pending_q, pending_d;
  logic [NCHAN-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NCHAN-1:0]            pend_q, pend_d;
  logic [NCHAN-1:0]            wrap;

  assign div_v = div;

  always_comb begin
    wrap = '0;
    for (int i = 0; i < NCHAN; i++)
      wrap[i] = (cnt_q[i] == '0);
  end

  // A new divisor only takes effect at a wrap, so a period in progress is never altered.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    if (!resetn_q) begin
      shadow_d = div_v;
      cnt_d    = div_v;
      pend_d   = '0;
    end else begin
      if (load) begin
        pending_d = div_v;
        pend_d    = '1;
      end
      if (!freeze) begin
        for (int i = 0; i < NCHAN; i++) begin
          if (wrap[i]) begin
            if (load)
              shadow_d[i] = div_v[i];
            else if (pend_q[i])
              shadow_d[i] = pending_q[i];
            cnt_d[i]  = shadow_d[i];
            pend_d[i] = 1'b0;
          end else begin
            cnt_d[i] = cnt_q[i] - DIV_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge CLK) begin
    shadow_q  <= shadow_d;
    pending_q <= pending_d;
  end

  always_comb begin
    en = '0;
    if (resetn_q)
      en = freeze ? {NCHAN{step_pulse}} : wrap;
  end

  assign resetn = resetn_q;

endmodule

// File: tb/tb_clock_gearbox.sv
// tb_clock_gearbox: directed, table-driven bench for reset release, divide, deferred load and single step.
// Exercises the single-step path only when CLOCK_GEARBOX_SINGLE_STEP_EN is defined.
module tb_clock_gearbox;

  localparam int NCHAN        = 2;
  localparam int DIV_W        = 8;
  localparam int SYNC_STAGES  = 2;
  localparam int RESET_CYCLES = 8;
  localparam int RELEASE_EDGES = SYNC_STAGES + RESET_CYCLES + 1;

  logic                   clk = 1'b0;
  logic                   rst_in;
  logic [NCHAN*DIV_W-1:0] div;
  logic                   load;
  logic                   resetn;
  logic [NCHAN-1:0]       en;
`ifdef CLOCK_GEARBOX_SINGLE_STEP_EN
  logic                   step_mode;
  logic                   step;
`endif

  typedef struct {
    logic             ld;
    logic [DIV_W-1:0] d0;
    logic [NCHAN-1:0] en_exp;
  } vec_t;

  vec_t vecs [0:15];
  int   tests_run    = 0;
  int   tests_failed = 0;

  clock_gearbox #(
    .NCHAN       (NCHAN),
    .DIV_W       (DIV_W),
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_CYCLES(RESET_CYCLES)
`ifdef CLOCK_GEARBOX_SINGLE_STEP_EN
    ,
    .DEB_W       (4)
`endif
  ) dut (
    .CLK      (clk),
    .RESET    (rst_in),
    .div      (div),
    .load     (load),
`ifdef CLOCK_GEARBOX_SINGLE_STEP_EN
    .step_mode(step_mode),
    .step     (step),
`endif
    .resetn   (resetn),
    .en       (en)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input int i, input logic ld, input logic [DIV_W-1:0] d0, input logic [NCHAN-1:0] e);
    vecs[i].ld     = ld;
    vecs[i].d0     = d0;
    vecs[i].en_exp = e;
  endtask

  // Releases RESET between edges and follows the release sequence edge by edge; ends in cycle k=0.
  task automatic release_reset(input string name);
    @(negedge clk);
    rst_in = 1'b1;
    for (int e = 1; e <= RELEASE_EDGES; e++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("%s resetn edge %0d", name, e), resetn, (e == RELEASE_EDGES) ? 1 : 0);
      if (e < RELEASE_EDGES)
        check_output($sformatf("%s en edge %0d", name, e), en, 0);
    end
  endtask

  // Drops RESET between clock edges and expects outputs to fall without any clock.
  task automatic midrun_reset(input string name);
    check_output({name, " en[1] before drop"}, en[1], 1);
    #1;
    rst_in = 1'b0;
    #1;
    check_output({name, " resetn async"}, resetn, 0);
    check_output({name, " en async"}, en, 0);
  endtask

  task automatic apply_stimulus(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      div  = {8'd0, vecs[k].d0};
      load = vecs[k].ld;
      @(negedge clk);
      check_output($sformatf("%s k=%0d", name, k), en, vecs[k].en_exp);
      @(posedge clk);
      #1;
      load = 1'b0;
      div  = {8'd0, 8'd3};
    end
  endtask

  initial begin
    int first;
    int second;
    rst_in = 1'b0;
    load   = 1'b0;
    div    = {8'd0, 8'd3};
`ifdef CLOCK_GEARBOX_SINGLE_STEP_EN
    step_mode = 1'b0;
    step      = 1'b0;
`endif
    #3;
    check_output("boot resetn", resetn, 0);
    check_output("boot en", en, 0);
    release_reset("boot");

    for (int k = 0; k < 12; k++)
      put(k, 1'b0, 8'd3, (k % 4 == 3) ? 2'b11 : 2'b10);
    apply_stimulus("divide", 12);

    midrun_reset("mid");
    release_reset("rerelease");
    for (int k = 0; k < 12; k++)
      put(k, (k == 5), (k == 5) ? 8'd1 : 8'd3,
          (k == 3 || k == 7 || k == 9 || k == 11) ? 2'b11 : 2'b10);
    apply_stimulus("deferred load", 12);

    midrun_reset("mid2");
    release_reset("release2");
    for (int k = 0; k < 12; k++)
      put(k, (k == 3), (k == 3) ? 8'd0 : 8'd3, (k >= 3) ? 2'b11 : 2'b10);
    apply_stimulus("load at wrap", 12);

    midrun_reset("mid3");
    div = {8'd0, 8'hFF};
    release_reset("release3");
    first  = -1;
    second = -1;
    for (int k = 0; k < 520; k++) begin
      @(negedge clk);
      if (en[0]) begin
        if (first < 0)
          first = k;
        else if (second < 0)
          second = k;
      end
      @(posedge clk);
      #1;
    end
    check_output("all-ones first strobe", first, 255);
    check_output("all-ones second strobe", second, 511);

`ifdef CLOCK_GEARBOX_SINGLE_STEP_EN
    midrun_reset("mid4");
    div = {8'd0, 8'd3};
    release_reset("release4");
    @(negedge clk);
    check_output("step k0", en, 2'b10);
    @(posedge clk);
    #1;
    step_mode = 1'b1;
    for (int t = 0; t < 46; t++) begin
      step = (t == 0 || t == 1 || t == 5 || t == 6 || t == 35 || t == 36);
      @(negedge clk);
      check_output($sformatf("step t=%0d", t), en, (t == 3 || t == 38) ? 2'b11 : 2'b00);
      @(posedge clk);
      #1;
    end
    step      = 1'b0;
    step_mode = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      check_output($sformatf("resume t=%0d", t), en, (t == 2) ? 2'b11 : 2'b10);
      @(posedge clk);
      #1;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
